// File: rtl/operand_feeder.sv
// Purpose: buffers signed weight/pixel operand pairs and streams them in load order to a compute unit.
// Latency: one cycle from start (or stall release) to the pair appearing on weight/pixel; done one cycle after the last pair.
// Backpressure: stall holds the read index and emits zero operands; loads are refused (wr_ready=0) while streaming or full.
//
// Ports:
//   clock, rst_n                  - clock and asynchronous active-low reset
//   wr_en, wr_weight, wr_pixel    - load one operand pair (accepted when wr_ready)
//   wr_ready                      - a load this cycle is accepted
//   clear                         - empty the buffer (IDLE only, wins over wr_en/start)
//   start                         - stream all stored pairs (IDLE only)
//   stall                         - downstream hold request
//   weight, pixel                 - registered operands, zero when not valid
//   op_valid, op_last             - operand qualifiers; op_last marks the final stored pair
//   done                          - single-cycle pulse when a stream (or empty start) completes
//   busy                          - streaming in progress
//   count                         - number of stored pairs
module operand_feeder #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_weight,
  input  logic [DATA_W-1:0]        wr_pixel,
  output logic                     wr_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stall,
  output logic [DATA_W-1:0]        weight,
  output logic [DATA_W-1:0]        pixel,
  output logic                     op_valid,
  output logic                     op_last,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_w [DEPTH];
  logic [DATA_W-1:0] mem_p [DEPTH];

  logic [CW-1:0]     rd_idx, rd_idx_nxt, count_nxt, pres_idx;
  logic              load, present;
  logic [DATA_W-1:0] weight_nxt, pixel_nxt;
  logic              valid_nxt, last_nxt, done_nxt;

  assign busy     = (state == STREAM);
  assign wr_ready = (state == IDLE) && (count < DEPTH_C);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    count_nxt  = count;
    pres_idx   = rd_idx;
    load       = 1'b0;
    present    = 1'b0;
    done_nxt   = 1'b0;
    weight_nxt = '0;
    pixel_nxt  = '0;
    valid_nxt  = 1'b0;
    last_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (clear) begin
          count_nxt = '0;
        end else begin
          if (wr_en && wr_ready) begin
            load      = 1'b1;
            count_nxt = count + ONE_C;
          end
          if (start) begin
            if (count != '0) begin
              // Entry 0 goes out on the start edge itself unless the sink is stalled.
              state_nxt  = STREAM;
              pres_idx   = '0;
              rd_idx_nxt = '0;
              present    = !stall;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
      end

      STREAM: begin
        if (!stall) begin
          if (rd_idx < count) begin
            present = 1'b1;
          end else begin
            // All pairs presented: this edge closes the stream.
            state_nxt  = IDLE;
            rd_idx_nxt = '0;
            done_nxt   = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (present) begin
      weight_nxt = mem_w[pres_idx[AW-1:0]];
      pixel_nxt  = mem_p[pres_idx[AW-1:0]];
      valid_nxt  = 1'b1;
      // count_nxt covers a load accepted on the same edge as start.
      last_nxt   = (pres_idx == count_nxt - ONE_C);
      rd_idx_nxt = pres_idx + ONE_C;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_idx   <= '0;
      weight   <= '0;
      pixel    <= '0;
      op_valid <= 1'b0;
      op_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      count    <= count_nxt;
      rd_idx   <= rd_idx_nxt;
      weight   <= weight_nxt;
      pixel    <= pixel_nxt;
      op_valid <= valid_nxt;
      op_last  <= last_nxt;
      done     <= done_nxt;
    end
  end

  // Storage is retained across streams so a later start replays the same pairs.
  always_ff @(posedge clock) begin
    if (load) begin
      mem_w[count[AW-1:0]] <= wr_weight;
      mem_p[count[AW-1:0]] <= wr_pixel;
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
module tb_operand_feeder;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_weight, wr_pixel;
  logic              wr_ready;
  logic              clear, start, stall;
  logic [DATA_W-1:0] weight, pixel;
  logic              op_valid, op_last, done, busy;
  logic [3:0]        count;

  int checks = 0;
  int errors = 0;

  // Bench model of buffer contents, filled by the load task.
  logic [15:0] exp_w [DEPTH];
  logic [15:0] exp_p [DEPTH];
  int          mcount = 0;

  operand_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_weight (wr_weight),
    .wr_pixel  (wr_pixel),
    .wr_ready  (wr_ready),
    .clear     (clear),
    .start     (start),
    .stall     (stall),
    .weight    (weight),
    .pixel     (pixel),
    .op_valid  (op_valid),
    .op_last   (op_last),
    .done      (done),
    .busy      (busy),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [15:0] w, input logic [15:0] p);
    check_val("wr_ready_before_load", {31'd0, wr_ready}, {31'd0, mcount < DEPTH});
    wr_en = 1'b1; wr_weight = w; wr_pixel = p;
    tick();
    wr_en = 1'b0;
    if (mcount < DEPTH) begin
      exp_w[mcount] = w;
      exp_p[mcount] = p;
      mcount++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mcount = 0;
    check_val("count_after_clear", {28'd0, count}, 32'd0);
  endtask

  task automatic idle_zero(input string tag);
    check_val({tag, "_valid"}, {31'd0, op_valid}, 32'd0);
    check_val({tag, "_wp"}, {weight, pixel}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Streams mcount pairs; stall is held on edges stall_at .. stall_at+stall_len-1.
  task automatic run_stream(input int stall_at, input int stall_len);
    int idx = 0;
    start = 1'b1;
    for (int c = 0; c < mcount + stall_len + 1; c++) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      tick();
      start = 1'b0;
      if (stall) begin
        check_val("stall_valid", {31'd0, op_valid}, 32'd0);
        check_val("stall_last", {31'd0, op_last}, 32'd0);
        check_val("stall_wp", {weight, pixel}, 32'd0);
        check_val("stall_busy", {31'd0, busy}, 32'd1);
      end else if (idx < mcount) begin
        check_val("stream_weight", {16'd0, weight}, {16'd0, exp_w[idx]});
        check_val("stream_pixel", {16'd0, pixel}, {16'd0, exp_p[idx]});
        check_val("stream_valid", {31'd0, op_valid}, 32'd1);
        check_val("stream_last", {31'd0, op_last}, {31'd0, idx == mcount - 1});
        check_val("stream_busy", {31'd0, busy}, 32'd1);
        check_val("stream_done", {31'd0, done}, 32'd0);
        idx++;
      end else begin
        check_val("end_done", {31'd0, done}, 32'd1);
        idle_zero("end");
      end
    end
    stall = 1'b0;
    tick();
    check_val("done_one_cycle", {31'd0, done}, 32'd0);
    idle_zero("after_done");
  endtask

  task automatic load_six();
    load(16'(16),     16'(32));
    load(16'(0),      16'(255));
    load(16'(-25),    16'(255));
    load(16'(-256),   16'(-1024));
    load(16'(32767),  16'(32767));
    load(16'(-32768), 16'(-32768));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_weight = '0; wr_pixel = '0;
    clear = 1'b0; start = 1'b0; stall = 1'b0;
    tick(); tick();
    check_val("rst_count", {28'd0, count}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    idle_zero("rst");
    rst_n = 1'b1;
    tick();

    // Basic six-pair stream, then replay without reloading.
    load_six();
    check_val("count_six", {28'd0, count}, 32'd6);
    run_stream(100, 0);
    run_stream(100, 0);
    check_val("count_kept", {28'd0, count}, 32'd6);

    // Two-cycle stall while the third pair is due.
    run_stream(2, 2);

    // Stall on the start edge itself.
    run_stream(0, 1);

    // clear together with start: buffer empties, no stream, no done.
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0; mcount = 0;
    check_val("clr_start_count", {28'd0, count}, 32'd0);
    check_val("clr_start_done", {31'd0, done}, 32'd0);
    idle_zero("clr_start");
    tick();
    check_val("clr_start_done2", {31'd0, done}, 32'd0);

    // start with an empty buffer.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("empty_done", {31'd0, done}, 32'd1);
    idle_zero("empty");
    tick();
    check_val("empty_done_end", {31'd0, done}, 32'd0);

    // Overfill: nine writes into eight entries.
    for (int i = 0; i < 9; i++) load(16'(i * 1000 - 3000), 16'(7 - i * 13));
    check_val("full_count", {28'd0, count}, 32'd8);
    check_val("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    run_stream(100, 0);

    // Reset mid-stream after the second pair.
    do_clear();
    load_six();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("mid_w0", {16'd0, weight}, 32'd16);
    tick();
    check_val("mid_w1_valid", {31'd0, op_valid}, 32'd1);
    check_val("mid_p1", {16'd0, pixel}, 32'd255);
    rst_n = 1'b0;
    #1;
    idle_zero("async_rst");
    check_val("async_rst_last", {31'd0, op_last}, 32'd0);
    check_val("async_rst_count", {28'd0, count}, 32'd0);
    tick();
    check_val("async_rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1; mcount = 0;
    tick();
    check_val("post_rst_done", {31'd0, done}, 32'd0);
    check_val("post_rst_count", {28'd0, count}, 32'd0);
    check_val("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("post_rst_empty_done", {31'd0, done}, 32'd1);
    idle_zero("post_rst_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning the operand-pair buffer entries (power of two, 2..64).
REQ-002 The module SHALL have parameter DATA_W, default 16, meaning the signed operand width.
REQ-003 clock  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  load strobe for one operand pair.
REQ-006 wr_weight  input  DATA_W  signed weight to load.
REQ-007 wr_pixel  input  DATA_W  signed pixel to load.
REQ-008 wr_ready  output  1  high when a load is accepted this cycle.
REQ-009 clear  input  1  empties the buffer (entry count to 0).
REQ-010 start  input  1  begin streaming all stored pairs.
REQ-011 stall  input  1  downstream hold request.
REQ-012 weight  output  DATA_W  registered weight to the compute unit.
REQ-013 pixel  output  DATA_W  registered pixel to the compute unit.
REQ-014 op_valid  output  1  weight/pixel carry a real pair this cycle.
REQ-015 op_last  output  1  current pair is the final stored entry.
REQ-016 done  output  1  one-cycle pulse after the stream completes.
REQ-017 busy  output  1  high while state is STREAM.
REQ-018 count  output  $clog2(DEPTH)+1  number of stored pairs.

Function
REQ-019 FSM SHALL have states IDLE and STREAM; reset state IDLE.
REQ-020 In IDLE, wr_ready SHALL equal (count < DEPTH); in STREAM, wr_ready SHALL be 0.
REQ-021 A load (wr_en & wr_ready) SHALL write the pair at index count and increment count at the same edge; wr_en with wr_ready=0 SHALL be ignored, with no state change.
REQ-022 clear in IDLE SHALL set count to 0 at the next edge; clear SHALL take priority over a simultaneous wr_en or start; clear in STREAM SHALL be ignored.
REQ-023 start in IDLE with count>0 (and no clear) SHALL enter STREAM; at the same edge, if stall=0, outputs SHALL present entry 0 with op_valid=1 (one-cycle latency from start).
REQ-024 In STREAM, each edge with stall=0 SHALL present the next entry in load order; entries SHALL never be skipped or repeated.
REQ-025 Any edge with stall=1 SHALL drive op_valid=0, op_last=0, weight=0 and pixel=0 (zero product into the accumulator) and SHALL not advance the read index; release SHALL resume at the un-presented entry.
REQ-026 op_last SHALL be 1 exactly while entry count-1 is presented with op_valid=1.
REQ-027 The first non-stalled edge after the last entry SHALL return to IDLE with op_valid=0, weight=pixel=0, and done=1 for exactly one cycle.
REQ-028 start in IDLE with count=0 SHALL not enter STREAM and SHALL pulse done=1 for one cycle at the next edge, with op_valid remaining 0.
REQ-029 start during STREAM SHALL be ignored.
REQ-030 Stored entries SHALL be retained after streaming; a later start SHALL replay the same pairs (weight reuse).
REQ-031 Operands SHALL pass through bit-exact; no sign extension, truncation or arithmetic is applied.
REQ-032 Outside STREAM, weight and pixel SHALL be 0 and op_valid/op_last SHALL be 0.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, count=0, read index 0, weight=0, pixel=0, op_valid=0, op_last=0, done=0, busy=0; buffer contents need not be cleared.
REQ-034 Reset asserted mid-stream SHALL abort the stream with no done pulse; the first start after release with count=0 SHALL follow REQ-028.

Verification
REQ-035 Load (16,32),(0,255),(-25,255),(-256,-1024),(32767,32767),(-32768,-32768); start -> six consecutive op_valid cycles with these exact values; op_last on the 6th; done on the 7th cycle; busy high for 6 cycles.
REQ-036 Same load; stall=1 for 2 cycles while the 3rd pair is due -> two cycles with op_valid=0 and weight=pixel=0, then (-25,255) followed by the remaining three pairs; done appears 2 cycles later than in REQ-035.
REQ-037 Write 9 pairs with DEPTH=8 -> wr_ready=0 after the 8th, the 9th is dropped, count=8; start -> exactly 8 pairs streamed.
REQ-038 start with count=0 -> done pulse one cycle later, op_valid never asserted, busy stays 0.
REQ-039 Assert rst_n low after the 2nd pair is presented -> outputs 0 immediately, no done pulse; after release count=0 and wr_ready=1.
REQ-040 After REQ-035 completes, start again -> identical 6-pair replay; then clear together with start -> count=0, no stream, no done pulse.
